// File: rtl/ntt_coeff_loader.sv
// Streams signed coefficients into a dual-port polynomial RAM. It reduces each one into [0,Q-1] and writes even/odd pairs together.
// Each write lands one cycle after its odd coefficient is accepted; hold_i stalls acceptance only, never a write already scheduled.
module ntt_coeff_loader #(
    parameter int Q = 8380417,
    parameter int N = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        coeff_valid_i,
    input  logic [23:0] coeff_i,
    output logic        coeff_ready_o,
    input  logic        hold_i,
    output logic        wren_o,
    output logic [7:0]  addr1_o,
    output logic [7:0]  addr2_o,
    output logic [23:0] data1_o,
    output logic [23:0] data2_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam logic signed [24:0] QM1  = 25'(Q - 1);
    localparam logic [23:0]        QV   = 24'(Q);
    localparam logic [7:0]         LAST = 8'(N - 1);

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         idx;
    logic [23:0]        even_q;
    logic signed [24:0] coeff_s;
    logic               oor;
    logic               accept;
    logic [23:0]        red;

    always_comb begin
        coeff_s = $signed({coeff_i[23], coeff_i});
        oor     = (coeff_s > QM1) || (coeff_s < -QM1);
        if (oor)
            red = 24'd0;
        else if (coeff_i[23])
            red = coeff_i + QV;
        else
            red = coeff_i;
    end

    assign coeff_ready_o = (state == LOAD) && !hold_i;
    assign accept        = coeff_valid_i && coeff_ready_o;
    assign busy_o        = (state == LOAD) || (state == FLUSH);
    assign done_o        = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = LOAD;
            LOAD:    if (accept && idx == LAST) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            idx     <= 8'd0;
            even_q  <= 24'd0;
            wren_o  <= 1'b0;
            addr1_o <= 8'd0;
            addr2_o <= 8'd0;
            data1_o <= 24'd0;
            data2_o <= 24'd0;
            err_o   <= 1'b0;
        end else begin
            state  <= state_nxt;
            wren_o <= 1'b0;
            if (state == IDLE && start_i) begin
                idx   <= 8'd0;
                err_o <= 1'b0;
            end
            if (accept) begin
                idx <= idx + 8'd1;
                if (oor)
                    err_o <= 1'b1;
                // Even coefficient waits in even_q so both RAM ports write in the same cycle.
                if (!idx[0]) begin
                    even_q <= red;
                end else begin
                    wren_o  <= 1'b1;
                    addr1_o <= idx - 8'd1;
                    addr2_o <= idx;
                    data1_o <= even_q;
                    data2_o <= red;
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Randomized scoreboard bench for ntt_coeff_loader: the driver predicts RAM writes and done pulses, and a monitor checks them.
module tb_ntt_coeff_loader;

    localparam int Q = 8380417;
    localparam int N = 256;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        coeff_valid_i;
    logic [23:0] coeff_i;
    logic        coeff_ready_o;
    logic        hold_i;
    logic        wren_o;
    logic [7:0]  addr1_o;
    logic [7:0]  addr2_o;
    logic [23:0] data1_o;
    logic [23:0] data2_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    ntt_coeff_loader #(.Q(Q), .N(N)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .coeff_valid_i (coeff_valid_i),
        .coeff_i       (coeff_i),
        .coeff_ready_o (coeff_ready_o),
        .hold_i        (hold_i),
        .wren_o        (wren_o),
        .addr1_o       (addr1_o),
        .addr2_o       (addr2_o),
        .data1_o       (data1_o),
        .data2_o       (data2_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int cyc;
        int a1;
        int a2;
        int d1;
        int d2;
    } ev_t;

    ev_t expq[$];
    ev_t mev;
    int  coef[N];
    int  even_r;
    bit  err_exp;
    int  acc_first;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int reduce(input int c, output bit bad);
        bad = (c > Q - 1) || (c < -(Q - 1));
        if (bad) return 0;
        return (c < 0) ? c + Q : c;
    endfunction

    function automatic int rnd_coeff();
        return int'($urandom_range(0, 2 * (Q - 1))) - (Q - 1);
    endfunction

    // Monitor: every write or done pulse must match the head of the expected queue, including its cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (wren_o === 1'b1 || done_o === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: wren=%0b done=%0b addr1=%0d with nothing expected (cycle %0d)",
                             wren_o, done_o, addr1_o, cyc);
                end else begin
                    mev = expq.pop_front();
                    chk("ev_done_kind", done_o, mev.is_done);
                    chk("ev_wren_kind", wren_o, !mev.is_done);
                    chk("ev_cycle", cyc, mev.cyc);
                    if (!mev.is_done) begin
                        chk("addr1", addr1_o, mev.a1);
                        chk("addr2", addr2_o, mev.a2);
                        chk("data1", data1_o, mev.d1);
                        chk("data2", data2_o, mev.d2);
                    end
                end
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_wren", wren_o, 0);
        chk("rst_addr1", addr1_o, 0);
        chk("rst_addr2", addr2_o, 0);
        chk("rst_data1", data1_o, 0);
        chk("rst_data2", data2_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ready", coeff_ready_o, 0);
    endtask

    task automatic do_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        err_exp = 1'b0;
        even_r  = 0;
        chk("busy_after_start", busy_o, 1);
        chk("err_cleared_by_start", err_o, 0);
    endtask

    task automatic load_poly(input int n_acc, input int hold_after, input bit rnd_valid, input bit glitch);
        int i;
        int hold_left;
        int r;
        bit v;
        bit bad;
        i = 0;
        hold_left = 0;
        while (i < n_acc) begin
            @(negedge clk_i);
            chk("err_flag", err_o, err_exp);
            hold_i = (hold_left > 0);
            if (hold_left > 0) hold_left--;
            v = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            coeff_valid_i = v;
            coeff_i       = 24'(coef[i]);
            start_i       = glitch && ($urandom_range(0, 5) == 0);
            #1;
            chk("ready", coeff_ready_o, !hold_i);
            if (v && !hold_i) begin
                r = reduce(coef[i], bad);
                if (bad) err_exp = 1'b1;
                if (i == 0) acc_first = cyc;
                if (i % 2 == 0)
                    even_r = r;
                else
                    expq.push_back('{1'b0, cyc + 1, i - 1, i, even_r, r});
                if (i == N - 1)
                    expq.push_back('{1'b1, cyc + 2, 0, 0, 0, 0});
                if (i == hold_after) hold_left = 10;
                i++;
            end
        end
        @(negedge clk_i);
        coeff_valid_i = 1'b0;
        hold_i        = 1'b0;
        start_i       = 1'b0;
    endtask

    task automatic wait_done(input bit glitch_done, input bit check_latency);
        int t;
        t = 0;
        while (done_o !== 1'b1 && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done_o never rose within 20 cycles");
        end else if (check_latency) begin
            chk("done_latency", cyc - acc_first + 1, N + 2);
        end
        start_i = glitch_done;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("idle_after_done", busy_o, 0);
        chk("err_sticky_idle", err_o, err_exp);
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        coeff_valid_i = 1'b0;
        coeff_i = '0;
        hold_i = 1'b0;
        err_exp = 1'b0;
        even_r = 0;
        acc_first = 0;
        repeat (3) @(negedge clk_i);
        chk_reset_outputs();
        rst_i = 1'b0;

        // Ramp: coefficient equals its index, so each write's data equals its addresses.
        for (int i = 0; i < N; i++) coef[i] = i;
        do_start();
        load_poly(N, -1, 1'b0, 1'b0);
        wait_done(1'b0, 1'b1);

        // Negative wrap, an out-of-range value at idx 2, and random valid gaps.
        for (int i = 0; i < N; i++) coef[i] = rnd_coeff();
        coef[0] = -1;
        coef[1] = 5;
        coef[2] = Q;
        do_start();
        load_poly(N, -1, 1'b1, 1'b0);
        wait_done(1'b0, 1'b0);

        // Ten-cycle hold after idx 100, with stray start pulses during LOAD and DONE.
        for (int i = 0; i < N; i++) coef[i] = rnd_coeff();
        do_start();
        load_poly(N, 100, 1'b0, 1'b1);
        wait_done(1'b1, 1'b0);

        // Abandon after 37 accepts with a reset.
        for (int i = 0; i < N; i++) coef[i] = rnd_coeff();
        do_start();
        load_poly(37, -1, 1'b0, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_reset_outputs();
        rst_i = 1'b0;
        err_exp = 1'b0;
        repeat (6) @(negedge clk_i);
        chk("abort_queue_empty", expq.size(), 0);
        chk("abort_stays_idle", busy_o, 0);

        // Full restart with out-of-range extremes at both parities.
        for (int i = 0; i < N; i++) coef[i] = rnd_coeff();
        coef[2 * $urandom_range(0, N / 2 - 1) + 1] = -8388608;
        coef[2 * $urandom_range(0, N / 2 - 1)]     = 8388607;
        coef[N - 1] = -(Q - 1);
        do_start();
        load_poly(N, -1, 1'b0, 1'b0);
        wait_done(1'b1, 1'b1);

        for (int t = 0; t < 10 && expq.size() != 0; t++) @(negedge clk_i);
        chk("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ntt_coeff_loader.md
NTT_COEFF_LOADER -- requirements
Module: ntt_coeff_loader

Interface
REQ-001 Parameter: Q, default 8380417, modulus; all stored coefficients lie in [0, Q-1].
REQ-002 Parameter: N, default 256, coefficients per polynomial; N is even and at most 256.
REQ-003 Port: clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-005 Port: start_i  input  1  begin loading one polynomial; sampled only in IDLE.
REQ-006 Port: coeff_valid_i  input  1  coeff_i holds a valid coefficient.
REQ-007 Port: coeff_i  input  24  signed two's-complement coefficient, legal range [-(Q-1), Q-1].
REQ-008 Port: coeff_ready_o  output  1  loader accepts coeff_i this cycle.
REQ-009 Port: hold_i  input  1  NTT datapath owns the RAM; no transfer is accepted while high.
REQ-010 Port: wren_o  output  1  RAM write strobe for both ports.
REQ-011 Port: addr1_o  output  8  RAM port-1 address, even coefficient index.
REQ-012 Port: addr2_o  output  8  RAM port-2 address, odd coefficient index.
REQ-013 Port: data1_o  output  24  reduced even coefficient.
REQ-014 Port: data2_o  output  24  reduced odd coefficient.
REQ-015 Port: busy_o  output  1  high in LOAD and FLUSH.
REQ-016 Port: done_o  output  1  one-cycle pulse when the polynomial is fully written.
REQ-017 Port: err_o  output  1  sticky flag: an out-of-range coefficient was received.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, FLUSH and DONE.
REQ-019 IDLE: start_i=1 -> LOAD, clear the index counter, clear err_o.
REQ-020 coeff_ready_o SHALL equal (state==LOAD) AND NOT hold_i, driven combinationally.
REQ-021 A transfer SHALL occur only on coeff_valid_i AND coeff_ready_o; each transfer increments index idx (8 bits, 0..N-1).
REQ-022 Reduction: r = coeff_i + Q if coeff_i < 0, else r = coeff_i; r is 24 bits unsigned.
REQ-023 If coeff_i < -(Q-1) or coeff_i > Q-1, the loader SHALL set err_o, store r = 0, and still count the transfer.
REQ-024 An even-idx transfer SHALL latch r into an even holding register with no RAM write.
REQ-025 An odd-idx transfer SHALL, on the next cycle, drive wren_o=1, addr1_o=idx-1, addr2_o=idx, data1_o=held even value, data2_o=r, all registered, for exactly one cycle.
REQ-026 wren_o SHALL be 0 in every other cycle; address and data outputs hold their last values while wren_o=0.
REQ-027 The transfer with idx=N-1 SHALL move the FSM LOAD -> FLUSH; the final write issues in FLUSH; FLUSH -> DONE.
REQ-028 DONE SHALL assert done_o for one cycle, then go to IDLE; done_o is the cycle after the last wren_o.
REQ-029 Latency: one cycle from the accepting edge of an odd coefficient to wren_o.
REQ-030 start_i in LOAD, FLUSH or DONE SHALL be ignored.
REQ-031 hold_i asserted mid-polynomial SHALL stall acceptance only; a pending write already scheduled SHALL still issue.
REQ-032 Back-to-back valid with hold_i=0 SHALL sustain one coefficient per cycle; N coefficients complete in N+2 cycles after the first accept (N+1 cycles to the last wren_o).
REQ-033 err_o SHALL remain set through DONE and IDLE until the next accepted start_i.

Reset
REQ-034 rst_i=1 at a clock edge SHALL force IDLE, idx=0, holding register=0, wren_o=0, addr1_o=addr2_o=0, data1_o=data2_o=0, busy_o=0, done_o=0, err_o=0, coeff_ready_o=0.
REQ-035 Reset mid-LOAD SHALL abandon the polynomial with no further writes; a fresh start_i is required.

Verification
REQ-036 Stream 0..255 (coeff=idx), hold_i=0 -> 128 writes, write k has addr1_o=2k, addr2_o=2k+1, data equal to the addresses; done_o exactly 1 cycle after write 127.
REQ-037 coeff_i=-1 then 5 -> data1_o=8380416, data2_o=5 at addr 0/1; err_o=0.
REQ-038 coeff_i=8380417 at idx 2 -> err_o=1 from the next cycle, data1_o=0 at addr1_o=2; err_o clears only on the next start_i.
REQ-039 hold_i=1 for 10 cycles after idx 100 -> coeff_ready_o=0 and no accepts during the hold; all 256 values are still written correctly.
REQ-040 rst_i pulse after 37 accepts -> no wren_o after reset; a restarted load of 256 values completes normally.
REQ-041 start_i pulsed during LOAD and DONE -> no effect on idx, writes or done_o timing.
